// File: rtl/eq_serial_pkg.sv
// Shared types and helpers for the bit-serial equality checker.
package eq_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } eq_state_t;

  // Bits needed to index N positions, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/eq_serial.sv
// Bit-serial N-bit equality checker: LSB-first bit pairs under a start/valid
// handshake, reporting equality and the index of the lowest mismatching bit.
module eq_serial
  import eq_serial_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic [IDX_W-1:0] mism_idx
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  eq_state_t        r_state;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_mism_idx;
  logic             r_eq_acc;
  logic             r_found;
  logic             r_eq;
  logic             r_done;
  logic             r_ready;
  logic             r_busy;

  logic             w_match;
  logic             w_accept;

  // Same single xnor cell as the parallel comparator uses per bit.
  assign w_match  = a_bit ~^ b_bit;
  assign w_accept = start & r_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_mism_idx <= '0;
      r_eq_acc   <= 1'b0;
      r_found    <= 1'b0;
      r_eq       <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          // ready is low only in the DONE entry cycle, so nothing is taken then.
          if (w_accept) begin
            r_state    <= RUN;
            r_eq_acc   <= 1'b1;
            r_cnt      <= '0;
            r_mism_idx <= '0;
            r_found    <= 1'b0;
            r_eq       <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
          end else if (r_state == DONE) begin
            r_ready <= 1'b1;
            if (abort && r_ready) r_state <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            r_state <= IDLE;
            r_eq    <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (bit_valid) begin
            r_eq_acc <= r_eq_acc & w_match;
            if (!w_match && !r_found) begin
              r_mism_idx <= r_cnt;
              r_found    <= 1'b1;
            end
            if (r_cnt == LAST) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_eq    <= r_eq_acc & w_match;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign eq       = r_eq;
  assign mism_idx = r_mism_idx;

endmodule

// File: doc/eq_serial.md
Name: eq_serial

Overview:
- Bit-serial equality checker: consumes two N-bit words one bit pair per cycle, LSB first, under a start/valid handshake.
- Reports equality and the index of the first mismatching bit.
- Companion to the parallel N-bit equality comparator. Used where operands arrive serially (shift links, scan paths) and a parallel register-and-compare is too costly.
- Produces the same eq result the parallel comparator gives for the same two words.

Parameters:
- N, 4, word width in bits; N >= 1.
- IDX_W, $clog2(N) (min 1), width of bit index and counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new comparison; accepted only when ready=1.
- abort  input  1  cancel an in-progress comparison.
- bit_valid  input  1  a_bit/b_bit carry a valid bit pair this cycle.
- a_bit  input  1  serial bit of operand A, LSB first.
- b_bit  input  1  serial bit of operand B, LSB first.
- ready  output  1  block is idle or done and can accept start.
- busy  output  1  comparison in progress.
- done  output  1  one-cycle pulse when the Nth bit pair has been consumed.
- eq  output  1  1 = all N bit pairs matched; valid from the done cycle until the next accepted start.
- mism_idx  output  IDX_W  index of the lowest mismatching bit; 0 when eq=1.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, cnt=0.
  - ready=1, busy=0, done=0, eq=0, mism_idx=0.
- State IDLE:
  - ready=1.
  - start=1 -> RUN; eq_acc:=1, cnt:=0, mism_idx:=0, found:=0.
  - bit_valid is ignored in IDLE.
- State RUN:
  - busy=1, ready=0.
  - On each cycle with bit_valid=1:
    - eq_acc := eq_acc & ~(a_bit ^ b_bit).
    - If a_bit!=b_bit and found=0: mism_idx:=cnt, found:=1.
    - cnt:=cnt+1.
  - A bit_valid=1 cycle with cnt==N-1 consumes the last pair -> DONE next cycle.
  - bit_valid=0 stalls; no timeout.
  - start while in RUN is ignored.
  - abort=1 -> IDLE next cycle:
    - eq:=0, done not asserted.
    - Bit pairs presented in the abort cycle are discarded.
  - abort takes priority over bit_valid in the same cycle.
- State DONE:
  - Entry cycle: done=1 for exactly one cycle. eq=eq_acc is registered in that same cycle and is visible coincident with done.
  - After the entry cycle: ready=1, busy=0. eq and mism_idx hold.
  - start=1 -> RUN, same init as from IDLE. The held eq drops to 0 on the cycle after start is accepted.
  - abort in DONE -> IDLE. The held eq and mism_idx are kept.
- Latency: done asserts the cycle after the Nth valid bit pair. With back-to-back valids: start at cycle t, bits at t+1..t+N, done at t+N+1.
- Counter:
  - IDX_W bits, never exceeds N-1; no wrap in normal operation.
  - For N=1 the first valid pair completes the comparison.
- Only the first mismatch is recorded; later mismatches do not change mism_idx.
- Reset mid-operation: immediately returns all state and outputs to reset values. No partial result survives.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package eq_serial_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} eq_state_t.
  - function clog2_min1 for IDX_W.
- Single module; no sub-module needed.
- The per-bit match term is one xnor, matching the parallel comparator's cell.

Test Plan:
- N=4, start then A=1010b, B=1010b sent LSB first on 4 consecutive valid cycles -> done pulses exactly once at cycle 5 after start, eq=1, mism_idx=0.
- N=4, A=1010b vs B=1000b -> eq=0, mism_idx=1. Then A=0111b vs B=1110b -> eq=0, mism_idx=0 (first mismatch only).
- Stalls: same as the first case but bit_valid low on alternate cycles -> identical result; done 8 cycles after start; busy high throughout.
- Abort after 2 bit pairs, then a new start with equal words -> no done pulse for the aborted run; the second run gives eq=1. start pulsed during RUN is ignored (cnt is not reset).
- Async rst asserted mid-RUN, between clock edges -> outputs go to reset values immediately. After release, a full compare works and the prior partial bits have no effect.
- N=1 and N=8 instances, random words vs a parallel-compare reference model, 1000 iterations -> eq always equals (A==B). mism_idx equals the lowest set bit of A^B.
